// File: rtl/divisor_pkg.sv
// Shared constants and types for the restoring sequential divider.
package divisor_pkg;

  // Default divisor width; the dividend and the quotient are twice as wide.
  localparam int N  = 3;
  localparam int QW = 2 * N;                // dividend / quotient width
  localparam int AW = N + 1;                // partial remainder width
  localparam int CW = $clog2(2 * N + 1);    // iteration counter width

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/divisor_datapath.sv
// Restoring shift-subtract datapath: working registers A/Q/M, the trial
// subtractor and the registered result outputs.
module divisor_datapath
  import divisor_pkg::*;
#(
  parameter int N = divisor_pkg::N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           latch,
  input  logic [2*N-1:0] dividendo,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] cociente,
  output logic [N-1:0]   resto,
  output logic           div0
);

  localparam int DW = 2 * N;

  logic [N:0]    a;
  logic [DW-1:0] q;
  logic [N-1:0]  m;
  logic [N:0]    a_sh;
  logic [DW-1:0] q_sh;
  logic [N:0]    t;

  // Shift {A,Q} left and form the trial difference A - {0,M}.
  always_comb begin
    // NOTE: both outputs are fully assigned on every evaluation, so no latch can be inferred.
    {a_sh, q_sh} = {a, q} << 1;
    t            = a_sh - {1'b0, m};
  end

  // Working registers: load a new operation or retire one quotient bit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      a    <= '0;
      q    <= '0;
      m    <= '0;
      div0 <= 1'b0;
    end else if (load) begin
      a    <= '0;
      q    <= dividendo;
      m    <= divisor;
      div0 <= (divisor == '0);
    end else if (step) begin
      // A negative trial (MSB set) restores by keeping the shifted A.
      a <= t[N] ? a_sh : t;
      q <= {q_sh[DW-1:1], ~t[N]};
    end
  end

  // Result registers: capture the finished quotient/remainder, or the
  // divide-by-zero convention, and hold them until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cociente <= '0;
      resto    <= '0;
    end else if (latch) begin
      cociente <= div0 ? '1 : q;
      resto    <= div0 ? '0 : a[N-1:0];
    end
  end

endmodule

// File: rtl/divisor_nr.sv
// Sequential restoring divider: control FSM, iteration counter and the
// busy/fin handshake around divisor_datapath.
module divisor_nr
  import divisor_pkg::*;
#(
  parameter int N = divisor_pkg::N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividendo,
  input  logic [N-1:0]   divisor,
  output logic [2*N-1:0] cociente,
  output logic [N-1:0]   resto,
  output logic           busy,
  output logic           fin,
  output logic           div0
);

  localparam int                DW    = 2 * N;
  localparam int                CNT_W = $clog2(2 * N + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DW - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             load;
  logic             step;
  logic             latch;

  // Datapath strobes decoded from the current state; start only counts in IDLE.
  always_comb begin
    load  = (state == IDLE) && start;
    step  = (state == RUN);
    latch = (state == DONE);
  end

  // Control FSM with registered busy and fin. Results and fin leave DONE on
  // the same edge, so fin always coincides with freshly valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      fin   <= 1'b0;
    end else begin
      fin <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            busy  <= 1'b1;
            state <= (divisor == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          fin   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  divisor_datapath #(
    .N(N)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .latch     (latch),
    .dividendo (dividendo),
    .divisor   (divisor),
    .cociente  (cociente),
    .resto     (resto),
    .div0      (div0)
  );

endmodule

// File: tb/tb_divisor_nr.sv
// Self-checking bench for divisor_nr: directed scenarios plus randomized and
// exhaustive operand sweeps against a plain-arithmetic reference model.
module tb_divisor_nr;

  localparam int N      = 3;
  localparam int DW     = 2 * N;
  localparam int LAT    = 2 * N + 1;   // start edge to fin, non-zero divisor
  localparam int LAT_D0 = 1;           // start edge to fin, zero divisor
  localparam int ONES   = (1 << DW) - 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividendo;
  logic [N-1:0]  divisor;
  logic [DW-1:0] cociente;
  logic [N-1:0]  resto;
  logic          busy;
  logic          fin;
  logic          div0;

  int vectors     = 0;
  int miscompares = 0;

  divisor_nr #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .cociente  (cociente),
    .resto     (resto),
    .busy      (busy),
    .fin       (fin),
    .div0      (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer division with the zero-divisor convention.
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? ONES : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? 0 : a % b;
  endfunction

  function automatic int ref_lat(input int b);
    return (b == 0) ? LAT_D0 : LAT;
  endfunction

  // Issue one operation from IDLE and report how many edges after the start
  // edge fin was first seen (-1 if it never arrived within the budget).
  task automatic do_op(input int a, input int b, output int lat);
    @(negedge clk);
    dividendo = DW'(a);
    divisor   = N'(b);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (fin) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    dividendo = '0;
    divisor   = '0;
    @(posedge clk);
    #1;
    vectors++;
    if ({cociente, resto, div0, fin, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: q=%0d r=%0d div0=%b fin=%b busy=%b, expected all 0",
               cociente, resto, div0, fin, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    do_op(45, 6, lat);
    vectors++;
    if (lat !== LAT || cociente !== DW'(ref_q(45, 6)) || resto !== N'(ref_r(45, 6)) || div0 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_45_6: lat=%0d q=%0d r=%0d div0=%b, expected lat=%0d q=%0d r=%0d div0=0",
               lat, cociente, resto, div0, LAT, ref_q(45, 6), ref_r(45, 6));
    end
    @(posedge clk);
    #1;
    vectors++;
    if (fin !== 1'b0) begin
      miscompares++;
      $display("FAIL fin_single_cycle: fin=%b one edge after completion, expected 0", fin);
    end
  endtask

  task automatic test_boundary();
    int a_tab [3] = '{63, 5, 0};
    int b_tab [3] = '{1, 7, 3};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(a_tab[i], b_tab[i], lat);
      vectors++;
      if (lat !== LAT || cociente !== DW'(ref_q(a_tab[i], b_tab[i])) ||
          resto !== N'(ref_r(a_tab[i], b_tab[i]))) begin
        miscompares++;
        $display("FAIL boundary_%0d_%0d: lat=%0d q=%0d r=%0d, expected lat=%0d q=%0d r=%0d",
                 a_tab[i], b_tab[i], lat, cociente, resto, LAT,
                 ref_q(a_tab[i], b_tab[i]), ref_r(a_tab[i], b_tab[i]));
      end
    end
  endtask

  task automatic test_div0();
    int lat;
    do_op(20, 0, lat);
    vectors++;
    if (lat !== LAT_D0 || div0 !== 1'b1 || cociente !== DW'(ONES) || resto !== '0) begin
      miscompares++;
      $display("FAIL div0_20_0: lat=%0d div0=%b q=%0d r=%0d, expected lat=%0d div0=1 q=%0d r=0",
               lat, div0, cociente, resto, LAT_D0, ONES);
    end
    do_op(20, 4, lat);
    vectors++;
    if (lat !== LAT || div0 !== 1'b0 || cociente !== DW'(ref_q(20, 4)) || resto !== N'(ref_r(20, 4))) begin
      miscompares++;
      $display("FAIL after_div0_20_4: lat=%0d div0=%b q=%0d r=%0d, expected lat=%0d div0=0 q=%0d r=%0d",
               lat, div0, cociente, resto, LAT, ref_q(20, 4), ref_r(20, 4));
    end
  endtask

  // A second start pulsed on the third RUN edge must be ignored; outputs keep
  // the previous 20/4 result while the operation runs.
  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    dividendo = DW'(45);
    divisor   = N'(6);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1 || cociente !== DW'(ref_q(20, 4)) || resto !== N'(ref_r(20, 4)) || div0 !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_hold: busy=%b q=%0d r=%0d div0=%b, expected busy=1 q=%0d r=%0d div0=0",
               busy, cociente, resto, div0, ref_q(20, 4), ref_r(20, 4));
    end
    @(posedge clk);
    @(negedge clk);
    dividendo = DW'(9);
    divisor   = N'(2);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int e = 4; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (fin) begin
        lat = e;
        break;
      end
    end
    vectors++;
    if (lat !== LAT || cociente !== DW'(ref_q(45, 6)) || resto !== N'(ref_r(45, 6))) begin
      miscompares++;
      $display("FAIL busy_ignore: lat=%0d q=%0d r=%0d, expected lat=%0d q=%0d r=%0d",
               lat, cociente, resto, LAT, ref_q(45, 6), ref_r(45, 6));
    end
  endtask

  // Start held high: the second operation is accepted in the idle cycle that
  // follows DONE, so the two fin pulses are LAT+1 edges apart.
  task automatic test_back_to_back();
    int first  = -1;
    int second = -1;
    @(negedge clk);
    dividendo = DW'(45);
    divisor   = N'(6);
    start     = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (fin) begin
        if (first < 0) begin
          first = e;
          vectors++;
          if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle_busy: busy=%b in the fin cycle, expected 0", busy);
          end
        end else begin
          second = e;
          start  = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (first !== LAT || second !== 2 * LAT + 1 ||
        cociente !== DW'(ref_q(45, 6)) || resto !== N'(ref_r(45, 6))) begin
      miscompares++;
      $display("FAIL back_to_back: fin edges %0d,%0d q=%0d r=%0d, expected %0d,%0d q=%0d r=%0d",
               first, second, cociente, resto, LAT, 2 * LAT + 1, ref_q(45, 6), ref_r(45, 6));
    end
  endtask

  task automatic test_reset_mid();
    int  lat;
    logic fin_seen = 1'b0;
    @(negedge clk);
    dividendo = DW'(50);
    divisor   = N'(3);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({cociente, resto, div0, fin, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: q=%0d r=%0d div0=%b fin=%b busy=%b, expected all 0",
               cociente, resto, div0, fin, busy);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (fin) fin_seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * LAT) begin
      @(posedge clk);
      #1;
      if (fin || busy) fin_seen = 1'b1;
    end
    vectors++;
    if (fin_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_abort: fin or busy observed after abort, expected none");
    end
    do_op(50, 3, lat);
    vectors++;
    if (lat !== LAT || cociente !== DW'(ref_q(50, 3)) || resto !== N'(ref_r(50, 3))) begin
      miscompares++;
      $display("FAIL reset_mid_restart: lat=%0d q=%0d r=%0d, expected lat=%0d q=%0d r=%0d",
               lat, cociente, resto, LAT, ref_q(50, 3), ref_r(50, 3));
    end
  endtask

  task automatic test_random();
    int lat;
    int a;
    int b;
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, ONES));
      b = int'($urandom_range(0, (1 << N) - 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_op(a, b, lat);
      vectors++;
      if (lat !== ref_lat(b) || cociente !== DW'(ref_q(a, b)) ||
          resto !== N'(ref_r(a, b)) || div0 !== (b == 0)) begin
        miscompares++;
        $display("FAIL random_%0d_%0d: lat=%0d q=%0d r=%0d div0=%b, expected lat=%0d q=%0d r=%0d div0=%b",
                 a, b, lat, cociente, resto, div0, ref_lat(b), ref_q(a, b), ref_r(a, b), (b == 0));
      end
    end
  endtask

  // Every non-zero operand pair must satisfy a = q*b + r with r < b.
  task automatic test_exhaustive();
    int lat;
    for (int a = 0; a <= ONES; a++) begin
      for (int b = 1; b < (1 << N); b++) begin
        do_op(a, b, lat);
        vectors++;
        if (lat !== LAT || int'(cociente) * b + int'(resto) !== a || int'(resto) >= b) begin
          miscompares++;
          $display("FAIL exhaustive_%0d_%0d: lat=%0d q=%0d r=%0d, expected lat=%0d q=%0d r=%0d",
                   a, b, lat, cociente, resto, LAT, a / b, a % b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div0();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divisor_nr.md
DIVISOR_NR -- requirements
Module: divisor_nr

Interface
REQ-001 Parameter: N, default 3, divisor width; dividend and quotient width is 2N.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  operation request, sampled on rising clk edge.
REQ-005 dividendo  input  2N  unsigned dividend, sampled with start.
REQ-006 divisor  input  N  unsigned divisor, sampled with start.
REQ-007 cociente  output  2N  quotient, registered.
REQ-008 resto  output  N  remainder, registered.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 fin  output  1  one-cycle completion pulse.
REQ-011 div0  output  1  divide-by-zero flag, valid with fin and held until the next accepted start.

Function
REQ-012 The algorithm SHALL be restoring, sequential, shift-subtract, one quotient bit per clock.
REQ-013 The working registers SHALL be:
  - A: partial remainder, N+1 bits.
  - Q: dividend/quotient, 2N bits.
  - M: divisor, N bits.
  - count: ceil(log2(2N+1)) bits.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1, the edge SHALL:
  - load A=0, Q=dividendo, M=divisor, count=0;
  - clear div0;
  - go to RUN if divisor!=0, otherwise go to DONE with div0=1.
REQ-016 Each RUN edge SHALL:
  - shift {A,Q} left by 1;
  - compute T=A-{0,M} (N+1 bits);
  - if T non-negative (MSB=0), set A=T and Q[0]=1;
  - else keep the shifted A and set Q[0]=0;
  - increment count.
REQ-017 RUN SHALL go to DONE on the edge that completes iteration 2N (count reaches 2N).
REQ-018 On entry to DONE the block SHALL copy cociente=Q and resto=A[N-1:0].
  - fin=1 for exactly the DONE cycle.
  - DONE always returns to IDLE on the next edge.
REQ-019 When div0=1, the block SHALL output cociente=all ones and resto=0.
REQ-020 Latency SHALL be:
  - start accepted at edge k, fin high in the cycle after edge k+2N+1 (N=3: 7 edges);
  - divide-by-zero: fin high in the cycle after edge k+1.
REQ-021 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 start while busy=1 SHALL be ignored, with no effect on registers or outputs.
REQ-023 start high in the DONE cycle SHALL be ignored; it is accepted only if still high in IDLE.
REQ-024 cociente, resto and div0 SHALL hold their last values from fin until the next DONE, and SHALL NOT change during RUN.
REQ-025 Results SHALL satisfy dividendo = cociente*divisor + resto with resto < divisor, for every divisor != 0.
REQ-026 dividendo < divisor SHALL give cociente=0 and resto=dividendo.

Reset
REQ-027 rst_n=0 SHALL immediately force:
  - state=IDLE;
  - A, Q, M, count = 0;
  - cociente=0, resto=0, div0=0, fin=0, busy=0.
REQ-028 Reset asserted mid-operation SHALL abort it with no fin pulse.
  - Old results are not retained.
  - The first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-029 A shared package divisor_pkg SHALL hold:
  - N;
  - derived widths (2N, N+1, count width);
  - the state enumeration IDLE/RUN/DONE.
REQ-030 The block SHALL split into divisor_nr (control FSM, count, busy/fin) and one sub-module divisor_datapath.
  - divisor_datapath holds A/Q/M, the subtractor and the output registers.
  - divisor_datapath is driven by load, step and latch control signals.
REQ-031 All state-holding logic SHALL be clocked by clk, with rst_n as its asynchronous clear.

Verification
REQ-032 45/6 -> cociente=7, resto=3, div0=0, fin exactly 7 edges after the start edge, single-cycle fin.
REQ-033 Boundary cases:
  - 63/1 -> cociente=63, resto=0;
  - 5/7 -> cociente=0, resto=5;
  - 0/3 -> cociente=0, resto=0.
REQ-034 20/0 -> div0=1, cociente=63, resto=0, fin 1 edge after the start edge; the next 20/4 gives div0=0, cociente=5, resto=0.
REQ-035 Busy handling:
  - start 45/6, then pulse start with 9/2 on the third RUN edge -> the second request is ignored and the result is 7/3;
  - held start -> back-to-back operations, with one idle cycle between DONE and the next RUN.
REQ-036 Reset mid-operation: start 50/3, assert rst_n=0 after 3 RUN edges -> all outputs 0 immediately and no fin; after release, 50/3 -> cociente=16, resto=2.
REQ-037 Exhaustive self-check: all 64x7 non-zero operand pairs checked against REQ-025.
